// File: rtl/uart_rxd.sv
// UART 8N1 receiver with 16x oversampling. A two-flop synchronizer feeds a
// tick-driven start/data/stop FSM that emits one-clk valid or framing-error strobes.
module uart_rxd #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_in,
  output logic [7:0] rxd_data_out,
  output logic       rxd_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nx;
  logic            r_sync1, r_sync2, r_prev;
  logic [CW-1:0]   r_tick_cnt;
  logic            w_tick;
  logic [3:0]      r_sample_cnt, w_sample_cnt_nx;
  logic [2:0]      r_bit_idx, w_bit_idx_nx;
  logic [7:0]      r_shift, w_shift_nx;
  logic [7:0]      r_data, w_data_nx;
  logic            r_valid, w_valid_nx;
  logic            r_ferr, w_ferr_nx;

  assign w_tick        = (r_tick_cnt == TICK_MAX);
  assign rxd_data_out  = r_data;
  assign rxd_valid     = r_valid;
  assign framing_error = r_ferr;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b1;
      r_tick_cnt   <= '0;
      r_state      <= S_IDLE;
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_sync1      <= rxd_in;
      r_sync2      <= r_sync1;
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick)
        r_prev     <= r_sync2;
      r_state      <= w_state_nx;
      r_sample_cnt <= w_sample_cnt_nx;
      r_bit_idx    <= w_bit_idx_nx;
      r_shift      <= w_shift_nx;
      r_data       <= w_data_nx;
      r_valid      <= w_valid_nx;
      r_ferr       <= w_ferr_nx;
    end
  end

  // Counters are tested before incrementing, so mid-start lands 8 ticks after detection.
  always_comb begin
    w_state_nx      = r_state;
    w_sample_cnt_nx = r_sample_cnt;
    w_bit_idx_nx    = r_bit_idx;
    w_shift_nx      = r_shift;
    w_data_nx       = r_data;
    w_valid_nx      = 1'b0;
    w_ferr_nx       = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (r_prev && !r_sync2) begin
            w_sample_cnt_nx = '0;
            w_state_nx      = S_START;
          end
        end
        S_START: begin
          if (r_sample_cnt == 4'd7) begin
            if (!r_sync2) begin
              w_sample_cnt_nx = '0;
              w_bit_idx_nx    = '0;
              w_state_nx      = S_DATA;
            end else begin
              w_state_nx      = S_IDLE;
            end
          end else begin
            w_sample_cnt_nx = r_sample_cnt + 4'd1;
          end
        end
        S_DATA: begin
          w_sample_cnt_nx = r_sample_cnt + 4'd1;
          if (r_sample_cnt == 4'd15) begin
            w_shift_nx[r_bit_idx] = r_sync2;
            w_bit_idx_nx          = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7)
              w_state_nx = S_STOP;
          end
        end
        S_STOP: begin
          w_sample_cnt_nx = r_sample_cnt + 4'd1;
          if (r_sample_cnt == 4'd15) begin
            if (r_sync2) begin
              w_data_nx  = r_shift;
              w_valid_nx = 1'b1;
            end else begin
              w_ferr_nx  = 1'b1;
            end
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

endmodule
